// File: rtl/mtm_alu_sin_tx.sv
// rtl/mtm_alu_sin_tx.sv - serial frame transmitter for the mtm_Alu sin line
module mtm_alu_sin_tx #(
    parameter int CLKS_PER_BIT = 1,
    parameter int GAP_BITS     = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [2:0]  req_op,
    input  logic [3:0]  req_ndata,
    input  logic [3:0]  req_crc_xor,
    output logic        sin,
    output logic        busy,
    output logic        done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_TYPE,
        S_DATA,
        S_STOP,
        S_GAP
    } state_t;

    state_t          r_state;
    logic [63:0]     r_payload;
    logic [2:0]      r_op;
    logic [3:0]      r_ndata;
    logic [3:0]      r_crc;
    logic [3:0]      r_pkt;
    logic [2:0]      r_bit;
    logic [GW-1:0]   r_gap;
    logic [CW-1:0]   r_cnt;
    logic            r_sin;
    logic            r_busy;
    logic            r_done;
    logic            r_ready;

    logic            w_last_pkt;
    logic [63:0]     w_shift;
    logic [7:0]      w_byte;
    logic            w_bit_end;
    logic [2:0]      w_next_bit;

    // Bit-serial CRC4 (x^4+x+1), init 0, MSB first.
    function automatic logic [3:0] crc4(input logic [67:0] msg);
        logic [3:0] c;
        logic       fb;
        c = 4'h0;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ msg[i];
            c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
        end
        return c;
    endfunction

    assign w_last_pkt = (r_pkt == r_ndata);
    assign w_shift    = r_payload << {r_pkt, 3'b000};
    assign w_byte     = w_last_pkt ? {1'b0, r_op, r_crc} : w_shift[63:56];
    assign w_bit_end  = (r_cnt == CNT_LAST);
    assign w_next_bit = r_bit - 3'd1;

    assign sin       = r_sin;
    assign busy      = r_busy;
    assign done      = r_done;
    assign req_ready = r_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_payload <= '0;
            r_op      <= '0;
            r_ndata   <= '0;
            r_crc     <= '0;
            r_pkt     <= '0;
            r_bit     <= '0;
            r_gap     <= '0;
            r_cnt     <= '0;
            r_sin     <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ready   <= 1'b1;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (req_valid) begin
                    r_payload <= {req_b, req_a};
                    r_op      <= req_op;
                    r_ndata   <= (req_ndata > 4'd8) ? 4'd8 : req_ndata;
                    r_crc     <= crc4({req_b, req_a, 1'b1, req_op}) ^ req_crc_xor;
                    r_pkt     <= '0;
                    r_cnt     <= '0;
                    r_sin     <= 1'b0;
                    r_busy    <= 1'b1;
                    r_ready   <= 1'b0;
                    r_state   <= S_START;
                end
            end else if (!w_bit_end) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
                case (r_state)
                    S_START: begin
                        r_sin   <= w_last_pkt;
                        r_state <= S_TYPE;
                    end
                    S_TYPE: begin
                        r_bit   <= 3'd7;
                        r_sin   <= w_byte[7];
                        r_state <= S_DATA;
                    end
                    S_DATA: begin
                        if (r_bit == 3'd0) begin
                            r_sin   <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_bit <= w_next_bit;
                            r_sin <= w_byte[w_next_bit];
                        end
                    end
                    S_STOP: begin
                        if (w_last_pkt) begin
                            r_sin   <= 1'b1;
                            r_busy  <= 1'b0;
                            r_ready <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else if (GAP_BITS > 0) begin
                            r_gap   <= '0;
                            r_sin   <= 1'b1;
                            r_state <= S_GAP;
                        end else begin
                            r_pkt   <= r_pkt + 4'd1;
                            r_sin   <= 1'b0;
                            r_state <= S_START;
                        end
                    end
                    S_GAP: begin
                        if (r_gap == GAP_LAST) begin
                            r_pkt   <= r_pkt + 4'd1;
                            r_sin   <= 1'b0;
                            r_state <= S_START;
                        end else begin
                            r_gap <= r_gap + 1'b1;
                        end
                    end
                    default: begin
                        r_sin   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mtm_alu_sin_tx.sv
// tb/tb_mtm_alu_sin_tx.sv - self-checking bench for mtm_alu_sin_tx
module tb_mtm_alu_sin_tx;

    logic        clk;
    logic        rst_n;
    logic        v1, v2;
    logic [31:0] req_a, req_b;
    logic [2:0]  req_op;
    logic [3:0]  req_ndata, req_crc_xor;
    logic        rdy1, sin1, busy1, done1;
    logic        rdy2, sin2, busy2, done2;

    int          n_pass  = 0;
    int          n_total = 0;
    logic        exp_q[$];

    mtm_alu_sin_tx dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(rdy1),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_ndata(req_ndata),
        .req_crc_xor(req_crc_xor), .sin(sin1), .busy(busy1), .done(done1)
    );

    mtm_alu_sin_tx #(.CLKS_PER_BIT(4), .GAP_BITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(v2), .req_ready(rdy2),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_ndata(req_ndata),
        .req_crc_xor(req_crc_xor), .sin(sin2), .busy(busy2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [3:0]  nd;
        logic [3:0]  xr;
        int          exp_len;
        string       name;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // CRC as the remainder of M(x)*x^4 divided by x^4+x+1.
    function automatic logic [3:0] crc_ref(input logic [67:0] m);
        logic [71:0] v;
        v = {m, 4'b0000};
        for (int i = 71; i >= 4; i--)
            if (v[i]) v[i -: 5] = v[i -: 5] ^ 5'b10011;
        return v[3:0];
    endfunction

    task automatic push(input logic v, input int k);
        for (int i = 0; i < k; i++) exp_q.push_back(v);
    endtask

    task automatic build_exp(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                             input logic [3:0] nd, input logic [3:0] xr, input int cpb, input int gp);
        logic [63:0] pl;
        logic [7:0]  byt;
        logic [3:0]  c;
        int          n;
        pl = {b, a};
        n  = (nd > 8) ? 8 : int'(nd);
        c  = crc_ref({b, a, 1'b1, op}) ^ xr;
        exp_q.delete();
        for (int p = 0; p <= n; p++) begin
            byt = (p == n) ? {1'b0, op, c} : pl[63 - 8*p -: 8];
            push(1'b0, cpb);
            push(p == n, cpb);
            for (int j = 7; j >= 0; j--) push(byt[j], cpb);
            push(1'b1, cpb);
            if (p < n) push(1'b1, gp * cpb);
        end
    endtask

    function automatic logic o_sin(input bit sel);   return sel ? sin2  : sin1;  endfunction
    function automatic logic o_busy(input bit sel);  return sel ? busy2 : busy1; endfunction
    function automatic logic o_rdy(input bit sel);   return sel ? rdy2  : rdy1;  endfunction
    function automatic logic o_done(input bit sel);  return sel ? done2 : done1; endfunction

    // Called and returns on a negedge; returns in the done cycle.
    task automatic send(input bit sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic [3:0] nd, input logic [3:0] xr,
                        input int exp_len, input bit keep, input string nm);
        int cpb, gp, errs, rerr, cyc;
        cpb  = sel ? 4 : 1;
        gp   = sel ? 2 : 0;
        errs = 0;
        rerr = 0;
        cyc  = 0;
        build_exp(a, b, op, nd, xr, cpb, gp);
        req_a = a; req_b = b; req_op = op; req_ndata = nd; req_crc_xor = xr;
        if (sel) v2 = 1'b1; else v1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!keep) begin v1 = 1'b0; v2 = 1'b0; end
        while (o_busy(sel) && cyc < 3000) begin
            if (cyc >= exp_q.size() || o_sin(sel) !== exp_q[cyc]) errs++;
            if (o_rdy(sel) || o_done(sel)) rerr++;
            cyc++;
            @(negedge clk);
        end
        chk({nm, "_len"}, cyc, exp_len);
        chk({nm, "_bits"}, errs, 0);
        chk({nm, "_ready_done_low"}, rerr, 0);
        chk({nm, "_done"}, o_done(sel), 1);
        chk({nm, "_idle"}, {o_sin(sel), o_rdy(sel)}, 2'b11);
    endtask

    initial begin
        int n;
        int dcnt;
        logic [31:0] ra, rb;
        logic [3:0]  rnd;

        vecs[0] = '{32'h0000_0001, 32'h0000_0002, 3'b000, 4'd8,  4'h0, 99, "t1_full"};
        vecs[1] = '{32'h1234_5678, 32'hAABB_CCDD, 3'b010, 4'd3,  4'h0, 44, "t3_nd3"};
        vecs[2] = '{32'h0000_0001, 32'h0000_0002, 3'b000, 4'd8,  4'hF, 99, "t4_crcxor"};
        vecs[3] = '{32'hDEAD_BEEF, 32'h0BAD_F00D, 3'b101, 4'd0,  4'h0, 11, "n0_ctl_only"};
        vecs[4] = '{32'hCAFE_0123, 32'h7654_3210, 3'b111, 4'd13, 4'h5, 99, "nd_clamp"};

        rst_n = 1'b0; v1 = 1'b0; v2 = 1'b0;
        req_a = '0; req_b = '0; req_op = '0; req_ndata = '0; req_crc_xor = '0;
        repeat (2) @(negedge clk);
        chk("reset_dut1", {sin1, busy1, done1, rdy1}, 4'b1001);
        chk("reset_dut2", {sin2, busy2, done2, rdy2}, 4'b1001);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            send(1'b0, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].nd, vecs[i].xr,
                 vecs[i].exp_len, 1'b0, vecs[i].name);
            @(negedge clk);
            chk({vecs[i].name, "_done_once"}, done1, 0);
        end

        send(1'b0, 32'h1111_2222, 32'h3333_4444, 3'b001, 4'd2, 4'h0, 33, 1'b1, "b2b_first");
        send(1'b0, 32'h5555_6666, 32'h7777_8888, 3'b110, 4'd5, 4'h0, 66, 1'b0, "b2b_second");
        @(negedge clk);
        chk("b2b_done_once", done1, 0);

        send(1'b1, 32'h0000_0001, 32'h0000_0002, 3'b000, 4'd8, 4'h0, 460, 1'b0, "t5_cpb4_gap2");
        @(negedge clk);
        chk("t5_done_once", done2, 0);

        for (int i = 0; i < 12; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            rnd = 4'($urandom_range(0, 15));
            n   = (rnd > 8) ? 8 : int'(rnd);
            send(1'b0, ra, rb, 3'($urandom), rnd, 4'($urandom), (n + 1) * 11, 1'b0, "rand1");
        end
        for (int i = 0; i < 2; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            rnd = 4'($urandom_range(0, 9));
            n   = (rnd > 8) ? 8 : int'(rnd);
            send(1'b1, ra, rb, 3'($urandom), rnd, 4'($urandom),
                 (n + 1) * 44 + n * 8, 1'b0, "rand2");
        end
        @(negedge clk);

        req_a = 32'h0000_00FF; req_b = 32'h1234_5678; req_op = 3'b011;
        req_ndata = 4'd8; req_crc_xor = 4'h0;
        v1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v1 = 1'b0;
        repeat (48) @(negedge clk);
        chk("rst_pre_sin_busy", {sin1, busy1}, 2'b01);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", {sin1, busy1, done1, rdy1}, 4'b1001);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (done1 || !rdy1 || !sin1) dcnt++;
        end
        chk("rst_no_done_idle", dcnt, 0);
        send(1'b0, 32'h0000_0001, 32'h0000_0002, 3'b000, 4'd8, 4'h0, 99, 1'b0, "after_rst");
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
